// File: rtl/uart_pkg.sv
// Shared defaults and parameter sanity checks for the UART character FIFO.
package uart_pkg;

   localparam int DATA_BITS_DEFAULT = 8;
   localparam int FIFO_AW_DEFAULT   = 4;

   // True when the almost-full/almost-empty thresholds make sense for the depth.
   function automatic bit fifo_levels_ok(input int aw, input int af, input int ae);
      int depth;
      depth = 1 << aw;
      return (af >= 1) && (af <= depth) && (ae >= 0) && (ae < depth);
   endfunction

endpackage

// File: rtl/uart_fifo_if.sv
// Host-side bundle of the UART FIFO: push/pop handshake, control and status.
interface uart_fifo_if
   import uart_pkg::*;
#(
   parameter int DataBits   = DATA_BITS_DEFAULT,
   parameter int addr_width = FIFO_AW_DEFAULT
) ();

   logic                  wr;
   logic [DataBits-1:0]   w_data;
   logic                  rd;
   logic [DataBits-1:0]   r_data;
   logic                  flush;
   logic                  clr_err;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [addr_width:0]   count;
   logic                  overflow;
   logic                  underflow;

   // Agent driving pushes/pops and watching status.
   modport master (
      output wr, w_data, rd, flush, clr_err,
      input  r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   // The FIFO itself.
   modport slave (
      input  wr, w_data, rd, flush, clr_err,
      output r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write, combinational (fall-through) read.
module fifo_mem #(
   parameter int DataBits   = 8,
   parameter int addr_width = 4
) (
   input  logic                  clk,
   input  logic                  w_en,
   input  logic [addr_width-1:0] w_addr,
   input  logic [DataBits-1:0]   w_data,
   input  logic [addr_width-1:0] r_addr,
   output logic [DataBits-1:0]   r_data
);

   localparam int DEPTH = 2 ** addr_width;

   logic [DataBits-1:0] mem [DEPTH];

   // Store the incoming word; contents are never cleared, only overwritten.
   always_ff @(posedge clk) begin
      if (w_en) begin
         mem[w_addr] <= w_data;
      end
   end

   assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO between the UART shift engines and the host.
// Holds pointers, occupancy count, status flags and sticky error flags;
// storage lives in fifo_mem.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DataBits   = DATA_BITS_DEFAULT,
   parameter int addr_width = FIFO_AW_DEFAULT,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   uart_fifo_if.slave   bus
);

   localparam int DEPTH = 2 ** addr_width;
   localparam int CW    = addr_width + 1;

   if (!fifo_levels_ok(addr_width, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
      $error("uart_fifo: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
   end

   logic [addr_width-1:0] wr_ptr;
   logic [addr_width-1:0] rd_ptr;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;
   logic                  full;
   logic                  empty;
   logic                  wr_ok;
   logic                  rd_ok;
   logic                  ovf_set;
   logic                  unf_set;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // A push into a full FIFO is allowed only when a pop frees the head slot
   // in the same cycle; flush suppresses both directions.
   assign wr_ok   = bus.wr & (~full | bus.rd) & ~bus.flush;
   assign rd_ok   = bus.rd & ~empty & ~bus.flush;
   assign ovf_set = bus.wr & full & ~bus.rd & ~bus.flush;
   assign unf_set = bus.rd & empty & ~bus.flush;

   fifo_mem #(
      .DataBits   (DataBits),
      .addr_width (addr_width)
   ) u_mem (
      .clk    (clk),
      .w_en   (wr_ok & rst_n),
      .w_addr (wr_ptr),
      .w_data (bus.w_data),
      .r_addr (rd_ptr),
      .r_data (bus.r_data)
   );

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(wr_ok) - CW'(rd_ok);
      end
   end

   // Sticky error flags: clr_err clears, but a fresh error in the same cycle wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow  & ~bus.clr_err) | ovf_set;
         underflow <= (underflow & ~bus.clr_err) | unf_set;
      end
   end

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count >= CW'(AF_LEVEL));
   assign bus.almost_empty = (count <= CW'(AE_LEVEL));
   assign bus.count        = count;
   assign bus.overflow     = overflow;
   assign bus.underflow    = underflow;

endmodule

// File: tb/tb_uart_fifo.sv
// Randomised and directed bench for uart_fifo against a queue-based model.
module tb_uart_fifo;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int AF    = 3;
   localparam int AE    = 1;

   logic clk = 1'b0;
   logic rst_n;

   uart_fifo_if #(.DataBits(DW), .addr_width(AW)) bus ();

   uart_fifo #(
      .DataBits   (DW),
      .addr_width (AW),
      .AF_LEVEL   (AF),
      .AE_LEVEL   (AE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state.
   logic [DW-1:0] q[$];
   bit            m_ovf;
   bit            m_unf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply the FIFO rules to the model for one clock edge.
   task automatic model_step(input bit r_n, input bit fl, input bit w, input bit r,
                             input bit clr, input logic [DW-1:0] d);
      bit was_full, was_empty, new_ovf, new_unf;
      if (!r_n) begin
         q.delete();
         m_ovf = 0;
         m_unf = 0;
      end else if (fl) begin
         q.delete();
         if (clr) begin
            m_ovf = 0;
            m_unf = 0;
         end
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         new_ovf   = w && was_full && !r;
         new_unf   = r && was_empty;
         if (r && !was_empty) void'(q.pop_front());
         if (w && (!was_full || r)) q.push_back(d);
         if (clr) begin
            m_ovf = 0;
            m_unf = 0;
         end
         if (new_ovf) m_ovf = 1;
         if (new_unf) m_unf = 1;
      end
   endtask

   task automatic compare_all();
      int n;
      n = q.size();
      check("count",        32'(bus.count),        32'(n));
      check("empty",        32'(bus.empty),        32'(n == 0));
      check("full",         32'(bus.full),         32'(n == DEPTH));
      check("almost_full",  32'(bus.almost_full),  32'(n >= AF));
      check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
      check("overflow",     32'(bus.overflow),     32'(m_ovf));
      check("underflow",    32'(bus.underflow),    32'(m_unf));
      if (n > 0) check("r_data", 32'(bus.r_data), 32'(q[0]));
   endtask

   // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
   task automatic cycle(input bit r_n, input bit fl, input bit w, input bit r,
                        input bit clr, input logic [DW-1:0] d);
      rst_n       = r_n;
      bus.flush   = fl;
      bus.wr      = w;
      bus.rd      = r;
      bus.clr_err = clr;
      bus.w_data  = d;
      @(posedge clk);
      model_step(r_n, fl, w, r, clr, d);
      #1;
      compare_all();
   endtask

   task automatic push(input logic [DW-1:0] d);  cycle(1, 0, 1, 0, 0, d);  endtask
   task automatic pop();                         cycle(1, 0, 0, 1, 0, '0); endtask
   task automatic idle();                        cycle(1, 0, 0, 0, 0, '0); endtask

   initial begin
      logic [DW-1:0] seq [4];
      seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      rst_n = 1'b0;
      bus.flush = 0; bus.wr = 0; bus.rd = 0; bus.clr_err = 0; bus.w_data = '0;

      // 1: reset then idle
      cycle(0, 0, 0, 0, 0, '0);
      cycle(0, 0, 0, 0, 0, '0);
      idle();

      // 2: fill in order, then drain in order
      for (int i = 0; i < 4; i++) push(seq[i]);
      for (int i = 0; i < 4; i++) begin
         check("order_head", 32'(bus.r_data), 32'(seq[i]));
         pop();
      end

      // 3: overflow drop, drain, clear
      for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
      push(8'hEE);
      check("ovf_set", 32'(bus.overflow), 32'd1);
      for (int i = 0; i < 4; i++) pop();
      cycle(1, 0, 0, 0, 1, '0);
      check("ovf_clr", 32'(bus.overflow), 32'd0);

      // 4: full with simultaneous push/pop wraps pointers
      for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
      for (int i = 0; i < 6; i++) cycle(1, 0, 1, 1, 0, 8'h55);
      for (int i = 0; i < 4; i++) pop();

      // 5: empty with push+pop -> push wins, underflow set
      cycle(1, 0, 1, 1, 0, 8'h77);
      check("unf_head", 32'(bus.r_data), 32'h77);
      pop();
      cycle(1, 0, 0, 0, 1, '0);

      // 6: flush beats write; reset mid-stream
      for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
      cycle(1, 1, 1, 0, 0, 8'h99);
      push(8'h41); push(8'h42);
      cycle(0, 0, 0, 0, 0, '0);
      push(8'h3C);
      check("post_rst_head", 32'(bus.r_data), 32'h3C);
      pop();

      // Random traffic with occasional flush, clear and reset
      for (int i = 0; i < 600; i++) begin
         bit r_n, fl, w, r, clr;
         r_n = ($urandom_range(0, 79) != 0);
         fl  = ($urandom_range(0, 39) == 0);
         clr = ($urandom_range(0, 15) == 0);
         w   = ($urandom_range(0, 99) < 55);
         r   = ($urandom_range(0, 99) < 45);
         cycle(r_n, fl, w, r, clr, 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
